// File: rtl/online_mul_sequencer.sv
// Job-level controller for the radix-2 signed-digit online multiplier.
// Ports: start/abort job control, x/y digit handshake in, datapath enables,
//   refresh, counters, buffer addresses, p_digit/p_valid, busy/done/digit_err.
module online_mul_sequencer #(
  parameter int NUM_DIGITS   = 64,
  parameter int ADDR_WIDTH   = 7,
  parameter int ONLINE_DELAY = 3,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            x_in,
  input  logic [1:0]            y_in,
  output logic [1:0]            x_value_comp,
  output logic [1:0]            y_value_comp,
  output logic                  enable,
  output logic                  add_enable,
  output logic                  res_enable,
  output logic                  refresh,
  output logic [CNT_WIDTH-1:0]  counter,
  output logic [CNT_WIDTH-1:0]  shift_cnt,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]            p_value,
  output logic [1:0]            p_digit,
  output logic                  p_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  digit_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_FEED =
    CNT_WIDTH'(NUM_DIGITS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP =
    CNT_WIDTH'(NUM_DIGITS + ONLINE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] DELTA =
    CNT_WIDTH'(ONLINE_DELAY);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic                 err_q, err_d;

  // The illegal 10 code is forwarded as a zero digit.
  function automatic logic [1:0] dec(input logic [1:0] d);
    return (d == 2'b10) ? 2'b00 : d;
  endfunction

  always_ff @(posedge clk) begin
    if (!asyn_reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    err_d        = err_q;
    in_ready     = 1'b0;
    enable       = 1'b0;
    refresh      = 1'b0;
    done         = 1'b0;
    x_value_comp = 2'b00;
    y_value_comp = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        refresh   = !abort;
        counter_d = '0;
        err_d     = 1'b0;
        state_d   = S_FEED;
      end
      S_FEED: begin
        in_ready = !abort;
        enable   = in_valid && !abort;
        if (enable) begin
          x_value_comp = dec(x_in);
          y_value_comp = dec(y_in);
          counter_d    = counter_q + ONE;
          if (x_in == 2'b10 || y_in == 2'b10) err_d = 1'b1;
          if (counter_q == LAST_FEED) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        enable = !abort;
        if (enable) begin
          counter_d = counter_q + ONE;
          if (counter_q == LAST_STEP) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats every other transition, including a pending start.
    if (abort) begin
      state_d = S_IDLE;
      if (state_q == S_LOAD) begin
        counter_d = counter_q;
        err_d     = err_q;
      end
    end
  end

  // Product digit j is valid once delta operand digits have gone in.
  assign p_valid    = enable && (counter_q >= DELTA);
  assign res_enable = p_valid;
  assign add_enable = enable;
  assign p_digit    = p_value;
  assign busy       = (state_q != S_IDLE);
  assign counter    = counter_q;
  assign digit_err  = err_q;
  assign shift_cnt  = (counter_q >= DELTA) ? (counter_q - DELTA) : '0;
  assign wr_addr    = counter_q[ADDR_WIDTH-1:0];
  assign rd_addr    = wr_addr - ADDR_WIDTH'(ONLINE_DELAY);

endmodule

// File: tb/tb_online_mul_sequencer.sv
// Bench for online_mul_sequencer: randomized digit jobs against a
// job-timeline model, plus a narrow-address instance for wrap checks.
module tb_online_mul_sequencer;

  localparam int N   = 64;
  localparam int D   = 3;
  localparam int AW  = 7;
  localparam int AWN = 4;
  localparam int CW  = 11;

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid;
  logic [1:0] x_in, y_in, p_value;

  logic in_ready, enable, add_enable, res_enable, refresh;
  logic p_valid, busy, done, digit_err;
  logic [1:0] x_value_comp, y_value_comp, p_digit;
  logic [CW-1:0] counter, shift_cnt;
  logic [AW-1:0] wr_addr, rd_addr;

  logic n_in_ready, n_enable, n_add_enable, n_res_enable, n_refresh;
  logic n_p_valid, n_busy, n_done, n_digit_err;
  logic [1:0] n_xv, n_yv, n_p_digit;
  logic [CW-1:0] n_counter, n_shift_cnt;
  logic [AWN-1:0] n_wr_addr, n_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  online_mul_sequencer #(
    .NUM_DIGITS(N), .ADDR_WIDTH(AW),
    .ONLINE_DELAY(D), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .asyn_reset(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in),
    .x_value_comp(x_value_comp), .y_value_comp(y_value_comp),
    .enable(enable), .add_enable(add_enable),
    .res_enable(res_enable), .refresh(refresh),
    .counter(counter), .shift_cnt(shift_cnt),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .p_value(p_value), .p_digit(p_digit), .p_valid(p_valid),
    .busy(busy), .done(done), .digit_err(digit_err)
  );

  online_mul_sequencer #(
    .NUM_DIGITS(N), .ADDR_WIDTH(AWN),
    .ONLINE_DELAY(D), .CNT_WIDTH(CW)
  ) dut_n (
    .clk(clk), .asyn_reset(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .x_in(x_in), .y_in(y_in),
    .x_value_comp(n_xv), .y_value_comp(n_yv),
    .enable(n_enable), .add_enable(n_add_enable),
    .res_enable(n_res_enable), .refresh(n_refresh),
    .counter(n_counter), .shift_cnt(n_shift_cnt),
    .wr_addr(n_wr_addr), .rd_addr(n_rd_addr),
    .p_value(p_value), .p_digit(n_p_digit), .p_valid(n_p_valid),
    .busy(n_busy), .done(n_done), .digit_err(n_digit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dec(input logic [1:0] d);
    return (d == 2'b10) ? 2'b00 : d;
  endfunction

  function automatic logic [1:0] rand_digit();
    int r;
    r = $urandom_range(2);
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step of FEED/FLUSH seen at the negedge; k = steps taken so far.
  task automatic step_check(input int k, input bit feed, input bit iv,
                            input logic [1:0] x, input logic [1:0] y,
                            input bit err);
    bit en;
    en = feed ? iv : 1'b1;
    chk("busy", busy, 1);
    chk("in_ready", in_ready, feed);
    chk("enable", enable, en);
    chk("add_enable", add_enable, en);
    chk("p_valid", p_valid, en && (k >= D));
    chk("res_enable", res_enable, en && (k >= D));
    chk("counter", counter, k);
    chk("shift_cnt", shift_cnt, (k >= D) ? k - D : 0);
    chk("wr_addr", wr_addr, k % (1 << AW));
    chk("rd_addr", rd_addr, (k - D) & ((1 << AW) - 1));
    chk("wr_addr_n", n_wr_addr, k % (1 << AWN));
    chk("rd_addr_n", n_rd_addr, (k - D) & ((1 << AWN) - 1));
    chk("x_value", x_value_comp, (feed && iv) ? dec(x) : 2'b00);
    chk("y_value", y_value_comp, (feed && iv) ? dec(y) : 2'b00);
    chk("digit_err", digit_err, err);
    chk("done_low", done, 0);
    chk("refresh_low", refresh, 0);
    chk("p_digit", p_digit, p_value);
  endtask

  // mode: 0 no stalls, 1 stall every other FEED cycle, 2 random stalls.
  task automatic run_job(input int mode, input int bad_idx,
                         input int abort_at, input bit bad_on_stall);
    int k, acc, cyc, feed_cyc, pv_obs, en_obs, hs_obs;
    bit err, feed, iv, en;
    logic [1:0] x, y;
    k = 0; acc = 0; cyc = 0; feed_cyc = 0;
    pv_obs = 0; en_obs = 0; hs_obs = 0; err = 1'b0;
    start = 1'b1; abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("start_idle_busy", busy, 0);
    chk("start_idle_ready", in_ready, 0);
    tick();
    start = 1'($urandom_range(1));
    in_valid = 1'b1;
    @(negedge clk);
    cyc = 1;
    chk("load_refresh", refresh, 1);
    chk("load_enable", enable, 0);
    chk("load_ready", in_ready, 0);
    chk("load_busy", busy, 1);
    tick();
    while (k < N + D) begin
      cyc++;
      if (cyc > 2000) begin
        checks++; errors++;
        $error("FAIL job_timeout observed=%0d expected=%0d", k, N + D);
        return;
      end
      feed = (acc < N);
      case (mode)
        1:       iv = feed ? 1'(feed_cyc % 2) : 1'($urandom_range(1));
        2:       iv = ($urandom_range(99) >= 30);
        default: iv = 1'b1;
      endcase
      x = rand_digit();
      y = rand_digit();
      if (feed && iv && acc == bad_idx) x = 2'b10;
      if (!iv && bad_on_stall) y = 2'b10;
      x_in = x; y_in = y; in_valid = iv;
      p_value = 2'($urandom);
      start = 1'($urandom_range(1));
      abort = (feed && abort_at >= 0 && k == abort_at);
      @(negedge clk);
      if (abort) begin
        chk("abort_enable", enable, 0);
        chk("abort_p_valid", p_valid, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_counter", counter, abort_at);
        tick();
        @(negedge clk);
        chk("abort_stay_idle", busy, 0);
        tick();
        return;
      end
      step_check(k, feed, iv, x, y, err);
      pv_obs += p_valid;
      en_obs += enable;
      hs_obs += (in_valid && in_ready);
      if (feed) feed_cyc++;
      en = feed ? iv : 1'b1;
      if (en) begin
        if (feed) begin
          acc++;
          if (x == 2'b10 || y == 2'b10) err = 1'b1;
        end
        k++;
      end
      tick();
    end
    cyc++;
    start = 1'b0; in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_enable", enable, 0);
    chk("done_counter", counter, N + D);
    chk("done_busy", busy, 1);
    chk("done_cycle", cyc, 2 + feed_cyc + D);
    if (mode == 0) chk("done_cycle_69", cyc, 69);
    chk("pv_count", pv_obs, N);
    chk("en_count", en_obs, N + D);
    chk("hs_count", hs_obs, N);
    tick();
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_counter", counter, N + D);
    chk("post_err", digit_err, err);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b0;
    x_in = 2'b00; y_in = 2'b00; p_value = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_enable", enable, 0);
      chk("rst_counter", counter, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_p_valid", p_valid, 0);
      chk("rst_err", digit_err, 0);
      chk("rst_rd_addr_n", n_rd_addr, 13);
      tick();
    end
    rst_n = 1'b1; start = 1'b0;
    tick();

    run_job(0, -1, -1, 1'b0);
    run_job(1, -1, -1, 1'b0);
    run_job(0, 5, -1, 1'b0);
    run_job(0, -1, -1, 1'b0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    tick();

    run_job(0, -1, 20, 1'b0);
    run_job(0, -1, -1, 1'b0);
    run_job(2, 40, -1, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; x_in = 2'b10; y_in = 2'b01;
    repeat (10) tick();
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_err", digit_err, 1);
    chk("mid_counter", counter, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counter", counter, 0);
    chk("mid_rst_err", digit_err, 0);
    chk("mid_rst_done", done, 0);
    tick();

    run_job(2, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
